// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between icache and dcache, dcache-first with
// a bounded dcache streak so instruction fetch cannot starve.
module mem_arbiter #(
    parameter int ADDR_WIDTH   = 28,
    parameter int DATA_WIDTH   = 128,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ic_req_valid,
    input  logic [ADDR_WIDTH-1:0] ic_req_addr,
    output logic                  ic_req_ready,
    output logic                  ic_resp_valid,
    output logic [DATA_WIDTH-1:0] ic_resp_data,
    input  logic                  dc_req_valid,
    input  logic                  dc_req_rnw,
    input  logic [ADDR_WIDTH-1:0] dc_req_addr,
    input  logic [DATA_WIDTH-1:0] dc_req_wdata,
    output logic                  dc_req_ready,
    output logic                  dc_resp_valid,
    output logic [DATA_WIDTH-1:0] dc_resp_data,
    output logic                  mem_req_valid,
    output logic                  mem_req_rnw,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic [DATA_WIDTH-1:0] mem_req_data,
    input  logic                  mem_req_ready,
    input  logic                  mem_resp_valid,
    input  logic [DATA_WIDTH-1:0] mem_resp_data,
    output logic                  busy
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t                r_state, w_next;
    logic                  r_owner_dc, r_rnw, r_ic_rv, r_dc_rv;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_data, r_ic_data, r_dc_data;
    logic [SW-1:0]         r_streak;
    logic                  w_idle, w_starved, w_grant_dc, w_grant_ic, w_accept, w_resp;

    assign w_idle     = (r_state == IDLE) && !reset;
    assign w_starved  = r_streak == SW'(STARVE_LIMIT);
    assign w_grant_dc = dc_req_valid && !(ic_req_valid && w_starved);
    assign w_grant_ic = ic_req_valid && !w_grant_dc;
    assign w_accept   = w_idle && (ic_req_valid || dc_req_valid);
    assign w_resp     = (r_state == WAIT) && mem_resp_valid;

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    w_next = w_accept ? ISSUE : IDLE;
            ISSUE:   w_next = mem_req_ready ? (r_rnw ? WAIT : IDLE) : ISSUE;
            WAIT:    w_next = mem_resp_valid ? IDLE : WAIT;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        ic_req_ready  = w_idle && w_grant_ic;
        dc_req_ready  = w_idle && w_grant_dc;
        mem_req_valid = r_state == ISSUE;
        busy          = r_state != IDLE;
        mem_req_rnw   = r_rnw;
        mem_req_addr  = r_addr;
        mem_req_data  = r_data;
        ic_resp_valid = r_ic_rv;
        ic_resp_data  = r_ic_data;
        dc_resp_valid = r_dc_rv;
        dc_resp_data  = r_dc_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner_dc <= 1'b0;
            r_rnw      <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
            r_streak   <= '0;
            r_ic_rv    <= 1'b0;
            r_dc_rv    <= 1'b0;
            r_ic_data  <= '0;
            r_dc_data  <= '0;
        end else begin
            r_ic_rv <= w_resp && !r_owner_dc;
            r_dc_rv <= w_resp && r_owner_dc;
            if (w_accept) begin
                r_owner_dc <= w_grant_dc;
                r_rnw      <= w_grant_dc ? dc_req_rnw : 1'b1;
                r_addr     <= w_grant_dc ? dc_req_addr : ic_req_addr;
                r_data     <= w_grant_dc ? dc_req_wdata : '0;
                // streak counts only dcache wins that made a waiting icache lose
                r_streak   <= (w_grant_dc && ic_req_valid) ? (w_starved ? r_streak : r_streak + 1'b1) : '0;
            end
            if (w_resp && !r_owner_dc) r_ic_data <= mem_resp_data;
            if (w_resp && r_owner_dc)  r_dc_data <= mem_resp_data;
        end
    end
endmodule
